// File: rtl/alu_multicycle_if.sv
// Request/response bundle for alu_multicycle: request handshake, operands,
// result handshake and status flags.
interface alu_multicycle_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [4:0]   op;
  logic [N-1:0] reg_source1;
  logic [N-1:0] reg_source2;
  logic [N-1:0] immg_source;
  logic         alusrc;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] reg_destiny;
  logic         zero;
  logic         carry;
  logic         overflow;
  logic         illegal;
  logic         busy;

  modport master (
    output in_valid, op, reg_source1, reg_source2, immg_source, alusrc, out_ready,
    input  in_ready, out_valid, reg_destiny, zero, carry, overflow, illegal, busy
  );

  modport slave (
    input  in_valid, op, reg_source1, reg_source2, immg_source, alusrc, out_ready,
    output in_ready, out_valid, reg_destiny, zero, carry, overflow, illegal, busy
  );
endinterface

// File: rtl/alu_multicycle.sv
// Multi-cycle ALU: single-cycle logic/arith ops, iterative shift-add multiply
// and restoring divide (one step per cycle), result held until consumed.
//
// state | meaning
// IDLE  | ready for a request
// CALC  | iterating MUL/MULHU/DIVU/REMU, one step per clock
// DONE  | result and flags presented, waiting for out_ready
module alu_multicycle #(
  parameter int N = 32
) (
  input logic          clk,
  input logic          rst_n,
  alu_multicycle_if.slave bus
);
  localparam int SHW = $clog2(N);
  localparam int CW  = SHW + 1;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t         state, state_nxt;
  logic [N-1:0]   b_q, hi_q, lo_q, res_q;
  logic [1:0]     op_q;
  logic [CW-1:0]  cnt_q;
  logic           zero_q, carry_q, overflow_q, illegal_q;

  logic           accept, is_long;
  logic [N-1:0]   a_in, b_in;
  logic [SHW-1:0] sh;
  logic [N:0]     add_w;
  logic [N-1:0]   res_s;
  logic           c_s, v_s, il_s;

  logic [N:0]     mul_sum, div_sh, div_diff;
  logic           div_ge;
  logic [N-1:0]   hi_nxt, lo_nxt, res_l;

  assign accept  = bus.in_valid && bus.in_ready;
  assign is_long = (bus.op[4:2] == 3'b100);
  assign a_in    = bus.reg_source1;
  assign b_in    = bus.alusrc ? bus.reg_source2 : bus.immg_source;
  assign sh      = b_in[SHW-1:0];
  assign add_w   = {1'b0, a_in} + {1'b0, b_in};

  always_comb begin
    res_s = '0;
    c_s   = 1'b0;
    v_s   = 1'b0;
    il_s  = 1'b0;
    case (bus.op)
      5'b00000: begin
        res_s = add_w[N-1:0];
        c_s   = add_w[N];
        v_s   = (a_in[N-1] == b_in[N-1]) && (res_s[N-1] != a_in[N-1]);
      end
      5'b00001: begin
        res_s = a_in - b_in;
        c_s   = (a_in < b_in);
        v_s   = (a_in[N-1] != b_in[N-1]) && (res_s[N-1] != a_in[N-1]);
      end
      5'b00010: res_s = a_in & b_in;
      5'b00011: res_s = a_in | b_in;
      5'b00100: res_s = a_in ^ b_in;
      5'b00101: res_s = {{(N-1){1'b0}}, (a_in == b_in)};
      5'b00110: res_s = {{(N-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      5'b01000: res_s = {{(N-1){1'b0}}, (a_in < b_in)};
      5'b01001: res_s = a_in << sh;
      5'b01010: res_s = a_in >> sh;
      5'b01011: res_s = $signed(a_in) >>> sh;
      5'b10000, 5'b10001, 5'b10010, 5'b10011: res_s = '0;
      default:  il_s = 1'b1;
    endcase
  end

  // {hi,lo} is the product register for MUL and the {remainder,quotient} pair for DIV
  assign mul_sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, b_q} : '0);
  assign div_sh   = {hi_q, lo_q[N-1]};
  assign div_ge   = (div_sh >= {1'b0, b_q});
  assign div_diff = div_sh - {1'b0, b_q};

  always_comb begin
    if (op_q[1]) begin
      hi_nxt = div_ge ? div_diff[N-1:0] : div_sh[N-1:0];
      lo_nxt = {lo_q[N-2:0], div_ge};
    end else begin
      hi_nxt = mul_sum[N:1];
      lo_nxt = {mul_sum[0], lo_q[N-1:1]};
    end
    res_l = op_q[0] ? hi_nxt : lo_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = is_long ? CALC : DONE;
      CALC: if (cnt_q == CW'(1)) state_nxt = DONE;
      DONE: if (bus.out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      b_q        <= '0;
      hi_q       <= '0;
      lo_q       <= '0;
      op_q       <= '0;
      cnt_q      <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      overflow_q <= 1'b0;
      illegal_q  <= 1'b0;
    end else if (accept) begin
      b_q   <= b_in;
      hi_q  <= '0;
      lo_q  <= a_in;
      op_q  <= bus.op[1:0];
      cnt_q <= is_long ? CW'(N) : '0;
      if (!is_long) begin
        res_q      <= res_s;
        zero_q     <= (res_s == '0) && !il_s;
        carry_q    <= c_s;
        overflow_q <= v_s;
        illegal_q  <= il_s;
      end
    end else if (state == CALC) begin
      hi_q  <= hi_nxt;
      lo_q  <= lo_nxt;
      cnt_q <= cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        res_q      <= res_l;
        zero_q     <= (res_l == '0);
        carry_q    <= 1'b0;
        overflow_q <= 1'b0;
        illegal_q  <= 1'b0;
      end
    end
  end

  assign bus.in_ready    = (state == IDLE);
  assign bus.out_valid   = (state == DONE);
  assign bus.busy        = (state != IDLE);
  assign bus.reg_destiny = res_q;
  assign bus.zero        = zero_q;
  assign bus.carry       = carry_q;
  assign bus.overflow    = overflow_q;
  assign bus.illegal     = illegal_q;
endmodule

// File: tb/tb_alu_multicycle.sv
// Self-checking bench for alu_multicycle (N=32): directed corner cases,
// backpressure, reset abort and randomized ops against an arithmetic model.
module tb_alu_multicycle;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int errors = 0;

  alu_multicycle_if #(.N(32)) bus ();

  alu_multicycle #(.N(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference: plain integer arithmetic on the opcode meaning
  function automatic void model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] r, output logic [3:0] f, output int lat);
    longint sa, sb, s;
    logic [63:0] p;
    logic c, v, il;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    s = 0; p = '0; c = 1'b0; v = 1'b0; il = 1'b0; r = '0; lat = 1;
    case (op)
      5'd0: begin
        p = 64'(a) + 64'(b); r = p[31:0]; c = p[32];
        s = sa + sb; v = (s != longint'($signed(s[31:0])));
      end
      5'd1: begin
        r = a - b; c = (a < b);
        s = sa - sb; v = (s != longint'($signed(s[31:0])));
      end
      5'd2: r = a & b;
      5'd3: r = a | b;
      5'd4: r = a ^ b;
      5'd5: r = (a == b) ? 32'd1 : 32'd0;
      5'd6: r = (sa < sb) ? 32'd1 : 32'd0;
      5'd8: r = (a < b) ? 32'd1 : 32'd0;
      5'd9: r = a << b[4:0];
      5'd10: r = a >> b[4:0];
      5'd11: begin s = sa >>> b[4:0]; r = s[31:0]; end
      5'd16: begin p = 64'(a) * 64'(b); r = p[31:0]; lat = 33; end
      5'd17: begin p = 64'(a) * 64'(b); r = p[63:32]; lat = 33; end
      5'd18: begin r = (b == 0) ? 32'hFFFF_FFFF : a / b; lat = 33; end
      5'd19: begin r = (b == 0) ? a : a % b; lat = 33; end
      default: il = 1'b1;
    endcase
    f = {(r == 0) && !il, c, v, il};
  endfunction

  task automatic run_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic src, input int hold, input string name);
    logic [31:0] er;
    logic [3:0]  ef, gf;
    int elat, lat;
    model(op, a, b, er, ef, elat);
    @(negedge clk);
    bus.op = op;
    bus.reg_source1 = a;
    bus.reg_source2 = src ? b : $urandom;
    bus.immg_source = src ? $urandom : b;
    bus.alusrc = src;
    bus.in_valid = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL %s in_ready before request: got %b want 1", name, bus.in_ready);
    end
    @(posedge clk);
    lat = 1;
    #1;
    bus.in_valid = 1'b0;
    bus.op = 5'($urandom);
    bus.reg_source1 = $urandom;
    bus.reg_source2 = $urandom;
    bus.immg_source = $urandom;
    bus.alusrc = 1'($urandom);
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      checks++;
      if (bus.out_valid !== 1'b0 || bus.busy !== 1'b1) begin
        errors++; $display("FAIL %s waiting: out_valid=%b busy=%b want 0/1", name, bus.out_valid, bus.busy);
      end
      @(posedge clk);
      lat++;
      #1;
    end
    checks++;
    if (lat != elat) begin
      errors++; $display("FAIL %s latency: got %0d want %0d", name, lat, elat);
    end
    gf = {bus.zero, bus.carry, bus.overflow, bus.illegal};
    checks++;
    if (bus.reg_destiny !== er) begin
      errors++; $display("FAIL %s result: got %h want %h", name, bus.reg_destiny, er);
    end
    checks++;
    if (gf !== ef) begin
      errors++; $display("FAIL %s flags zcvi: got %b want %b", name, gf, ef);
    end
    for (int i = 0; i < hold; i++) begin
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      gf = {bus.zero, bus.carry, bus.overflow, bus.illegal};
      checks++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.reg_destiny !== er || gf !== ef) begin
        errors++;
        $display("FAIL %s hold %0d: out_valid=%b in_ready=%b res=%h flags=%b want 1/0/%h/%b",
                 name, i, bus.out_valid, bus.in_ready, bus.reg_destiny, gf, er, ef);
      end
    end
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL %s in_ready in consume cycle: got %b want 0", name, bus.in_ready);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.busy !== 1'b0 || bus.reg_destiny !== er) begin
      errors++;
      $display("FAIL %s after consume: out_valid=%b in_ready=%b busy=%b res=%h want 0/1/0/%h",
               name, bus.out_valid, bus.in_ready, bus.busy, bus.reg_destiny, er);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.busy !== 1'b0 || bus.in_ready !== 1'b1 || bus.reg_destiny !== 32'd0 ||
        {bus.zero, bus.carry, bus.overflow, bus.illegal} !== 4'b0) begin
      errors++;
      $display("FAIL reset state: out_valid=%b busy=%b in_ready=%b res=%h flags=%b want 0/0/1/0/0000",
               bus.out_valid, bus.busy, bus.in_ready, bus.reg_destiny,
               {bus.zero, bus.carry, bus.overflow, bus.illegal});
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_directed();
    run_op(5'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, 0, "add_wrap");
    run_op(5'd1, 32'h8000_0000, 32'h1, 1'b1, 0, "sub_ovf");
    run_op(5'd17, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "mulhu_max");
    run_op(5'd16, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 0, "mul_max");
    run_op(5'd18, 32'd7, 32'd0, 1'b1, 0, "divu_by0");
    run_op(5'd19, 32'd7, 32'd0, 1'b1, 0, "remu_by0");
    run_op(5'd18, 32'd100, 32'd7, 1'b0, 0, "divu_100_7");
    run_op(5'd19, 32'd100, 32'd7, 1'b0, 0, "remu_100_7");
    run_op(5'd11, 32'h8000_0010, 32'h0000_0124, 1'b1, 0, "sra_mask");
    run_op(5'd9, 32'h0000_0003, 32'hFFFF_FFE1, 1'b0, 0, "sll_mask");
    run_op(5'd6, 32'hFFFF_FFFF, 32'h1, 1'b1, 0, "slt_neg");
    run_op(5'd8, 32'hFFFF_FFFF, 32'h1, 1'b1, 0, "sltu_big");
    run_op(5'd7, 32'h1234_5678, 32'h0, 1'b1, 0, "illegal_07");
    run_op(5'd31, 32'h0, 32'h0, 1'b1, 0, "illegal_31");
  endtask

  task automatic test_backpressure();
    run_op(5'd1, 32'd5, 32'd9, 1'b1, 5, "bp_sub");
    run_op(5'd19, 32'd1000, 32'd33, 1'b0, 5, "bp_remu");
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk);
    bus.op = 5'd18;
    bus.reg_source1 = 32'd100;
    bus.reg_source2 = 32'd7;
    bus.alusrc = 1'b1;
    bus.in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.reg_destiny !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid abort: busy=%b out_valid=%b in_ready=%b res=%h want 0/0/1/0",
               bus.busy, bus.out_valid, bus.in_ready, bus.reg_destiny);
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid === 1'b1) seen++;
    end
    checks++;
    if (seen != 0) begin
      errors++; $display("FAIL reset_mid no result: out_valid seen %0d cycles want 0", seen);
    end
    run_op(5'd0, 32'd2, 32'd3, 1'b0, 0, "add_after_reset");
  endtask

  task automatic test_back_to_back();
    run_op(5'd2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 0, "b2b_and");
    run_op(5'd3, 32'hF0F0_F0F0, 32'h0F0F_0000, 1'b0, 0, "b2b_or");
    run_op(5'd4, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1'b1, 0, "b2b_xor");
    run_op(5'd5, 32'h1234_5678, 32'h1234_5678, 1'b0, 0, "b2b_eq");
    run_op(5'd10, 32'h8000_0000, 32'd31, 1'b1, 0, "b2b_srl");
  endtask

  task automatic test_random();
    logic [4:0] op;
    logic [31:0] a, b;
    for (int i = 0; i < 80; i++) begin
      case ($urandom_range(0, 3))
        0: op = 5'(16 + $urandom_range(0, 3));
        1: op = 5'($urandom_range(0, 1));
        default: op = 5'($urandom_range(0, 31));
      endcase
      a = $urandom;
      b = ($urandom_range(0, 7) == 0) ? 32'd0 :
          ($urandom_range(0, 3) == 0) ? 32'($urandom_range(1, 300)) : 32'($urandom);
      run_op(op, a, b, 1'($urandom), $urandom_range(0, 2), "random");
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    bus.op = '0;
    bus.reg_source1 = '0;
    bus.reg_source2 = '0;
    bus.immg_source = '0;
    bus.alusrc = 1'b0;
    test_reset();
    test_directed();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
